// File: rtl/spike_readout.sv
// spike_readout: counts per-neuron spikes over WINDOW ce steps, then serially scans for the argmax neuron.
// Latency: out_valid rises NEURON_NUM+1 clk after the cycle presenting the final window ce (one scan per clk).
// Backpressure: result held stable in HOLD until out_ready; SPIKE_READOUT_TIE_FLAG_EN adds the class_tie output.
module spike_readout #(
    parameter int NEURON_NUM = 64,
    parameter int CNT_W      = 8,
    parameter int WINDOW     = 16,
    localparam int IDX_W     = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [NEURON_NUM-1:0] spike_in,
    input  logic                  start,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      class_idx,
    output logic [CNT_W-1:0]      class_count
`ifdef SPIKE_READOUT_TIE_FLAG_EN
    ,
    output logic                  class_tie
`endif
);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NEURON_NUM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q [NEURON_NUM];
    logic [WIN_W-1:0] win_q;
    logic [IDX_W-1:0] scan_ptr_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [CNT_W-1:0] best_cnt_q;
    logic [CNT_W-1:0] scan_val;
    logic             win_last;
    logic             scan_last;
    logic             scan_take;

    assign win_last  = ce && (win_q == WIN_LAST);
    assign scan_last = (scan_ptr_q == IDX_LAST);
    assign scan_val  = cnt_q[scan_ptr_q];
    // Neuron 0 seeds the best registers; later neurons must strictly beat them, so ties keep the lower index.
    assign scan_take = (scan_ptr_q == '0) || (scan_val > best_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = ACCUM;
            ACCUM:   if (win_last)  state_d = SCAN;
            SCAN:    if (scan_last) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURON_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            win_q      <= '0;
            scan_ptr_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NEURON_NUM; i++) begin
                            cnt_q[i] <= '0;
                        end
                        win_q <= '0;
                    end
                end
                ACCUM: begin
                    if (ce) begin
                        for (int i = 0; i < NEURON_NUM; i++) begin
                            if (spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
                                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                            end
                        end
                        win_q      <= win_q + WIN_W'(1);
                        scan_ptr_q <= '0;
                    end
                end
                SCAN: begin
                    if (scan_take) begin
                        best_idx_q <= scan_ptr_q;
                        best_cnt_q <= scan_val;
                    end
                    scan_ptr_q <= scan_last ? '0 : scan_ptr_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SPIKE_READOUT_TIE_FLAG_EN
    logic tie_q;

    // A new leader clears the flag; an equal count from a later neuron sets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tie_q <= 1'b0;
        end else if ((state_q == ACCUM) && win_last) begin
            tie_q <= 1'b0;
        end else if (state_q == SCAN) begin
            if (scan_take) begin
                tie_q <= 1'b0;
            end else if (scan_val == best_cnt_q) begin
                tie_q <= 1'b1;
            end
        end
    end

    assign class_tie = tie_q;
`endif

    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == HOLD);
    assign class_idx   = best_idx_q;
    assign class_count = best_cnt_q;

endmodule

// File: tb/tb_spike_readout.sv
// Directed bench for spike_readout: default instance (64 neurons, window 16) plus a small saturating instance.
module tb_spike_readout;
    logic        clk;
    logic        rst_n;

    logic        ce;
    logic [63:0] spike_in;
    logic        start;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  class_idx;
    logic [7:0]  class_count;

    logic        ce_s;
    logic [15:0] spike_s;
    logic        start_s;
    logic        busy_s;
    logic        valid_s;
    logic        ready_s;
    logic [3:0]  idx_s;
    logic [3:0]  count_s;
`ifdef SPIKE_READOUT_TIE_FLAG_EN
    logic        class_tie;
    logic        tie_s;
`endif

    int checks = 0;
    int errors = 0;

    spike_readout dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .spike_in    (spike_in),
        .start       (start),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .class_idx   (class_idx),
        .class_count (class_count)
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        ,
        .class_tie   (class_tie)
`endif
    );

    spike_readout #(.NEURON_NUM(16), .CNT_W(4), .WINDOW(20)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce_s),
        .spike_in    (spike_s),
        .start       (start_s),
        .busy        (busy_s),
        .out_valid   (valid_s),
        .out_ready   (ready_s),
        .class_idx   (idx_s),
        .class_count (count_s)
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        ,
        .class_tie   (tie_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus tasks start and end just after a falling edge.
    task automatic ce_step(input logic [63:0] sp);
        spike_in = sp;
        ce       = 1'b1;
        @(negedge clk);
        ce       = 1'b0;
        spike_in = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%0b required 1 within 100 cycles", name, out_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (class_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", class_idx); end
        checks++; if (class_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", class_count); end
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        checks++; if (class_tie !== 1'b0) begin errors++; $display("FAIL reset_tie: got %0b expected 0", class_tie); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] sp;
        sp = 64'd1 << 5;
        // ce in IDLE must not count
        ce_step(64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %0b expected 0", busy); end
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        for (int k = 0; k < 16; k++) ce_step(sp);
        repeat (63) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0 at 64 clk", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %0b expected 1 at 65 clk", out_valid); end
        checks++; if (class_idx !== 6'd5) begin errors++; $display("FAIL basic_idx: got %0d expected 5", class_idx); end
        checks++; if (class_count !== 8'd16) begin errors++; $display("FAIL basic_count: got %0d expected 16", class_count); end
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        checks++; if (class_tie !== 1'b0) begin errors++; $display("FAIL basic_tie: got %0b expected 0", class_tie); end
`endif
        do_accept();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %0b expected 0", busy); end
        checks++; if (class_idx !== 6'd5) begin errors++; $display("FAIL basic_retain_idx: got %0d expected 5", class_idx); end
    endtask

    task automatic test_tie();
        logic [63:0] sp;
        sp = (64'd1 << 3) | (64'd1 << 40);
        do_start();
        for (int k = 0; k < 16; k++) ce_step(k < 7 ? sp : 64'd0);
        wait_valid("tie");
        checks++; if (class_idx !== 6'd3) begin errors++; $display("FAIL tie_idx: got %0d expected 3", class_idx); end
        checks++; if (class_count !== 8'd7) begin errors++; $display("FAIL tie_count: got %0d expected 7", class_count); end
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        checks++; if (class_tie !== 1'b1) begin errors++; $display("FAIL tie_flag: got %0b expected 1", class_tie); end
`endif
        do_accept();
    endtask

    task automatic test_saturation();
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        // neuron 9 and 12 every step (both saturate at 15), neuron 2 on 14 steps
        for (int k = 0; k < 20; k++) begin
            spike_s = 16'h1200 | (k < 14 ? 16'h0004 : 16'h0000);
            ce_s    = 1'b1;
            @(negedge clk);
            ce_s    = 1'b0;
            spike_s = '0;
        end
        for (int i = 0; i < 40 && !valid_s; i++) @(negedge clk);
        checks++; if (valid_s !== 1'b1) begin errors++; $display("FAIL sat_timeout: valid=%0b required 1", valid_s); end
        checks++; if (count_s !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", count_s); end
        checks++; if (idx_s !== 4'd9) begin errors++; $display("FAIL sat_idx: got %0d expected 9", idx_s); end
`ifdef SPIKE_READOUT_TIE_FLAG_EN
        checks++; if (tie_s !== 1'b1) begin errors++; $display("FAIL sat_tie: got %0b expected 1", tie_s); end
`endif
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL sat_idle: got %0b expected 0", busy_s); end
    endtask

    task automatic test_backpressure();
        do_start();
        for (int k = 0; k < 16; k++) ce_step((64'd1 << 20) | (k < 10 ? (64'd1 << 21) : 64'd0));
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            start = (c == 5);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || class_idx !== 6'd20 || class_count !== 8'd16) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%0b idx=%0d count=%0d expected 1/20/16", c, out_valid, class_idx, class_count);
            end
        end
        do_accept();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %0b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %0b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored: busy=%0b expected 0", busy); end
    endtask

    task automatic test_ce_gaps();
        logic [63:0] sp;
        do_start();
        for (int k = 0; k < 16; k++) begin
            sp = '0;
            if (k < 12) sp = sp | (64'd1 << 7);
            if (k < 5)  sp = sp | (64'd1 << 50);
            ce_step(sp);
            if (k < 15) begin
                for (int g = 0; g < (k % 4); g++) begin
                    spike_in = (g % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h5555_5555_5555_5555;
                    @(negedge clk);
                end
                spike_in = '0;
            end
        end
        repeat (63) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid: got %0b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps_latency: got %0b expected 1", out_valid); end
        checks++; if (class_idx !== 6'd7) begin errors++; $display("FAIL gaps_idx: got %0d expected 7", class_idx); end
        checks++; if (class_count !== 8'd12) begin errors++; $display("FAIL gaps_count: got %0d expected 12", class_count); end
        do_accept();
    endtask

    task automatic test_async_reset();
        do_start();
        for (int k = 0; k < 8; k++) ce_step(64'd1 << 5);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b expected 0", out_valid); end
        checks++; if (class_count !== 8'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", class_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        for (int k = 0; k < 16; k++) ce_step(64'd0);
        wait_valid("zero");
        checks++; if (class_idx !== 6'd0) begin errors++; $display("FAIL zero_idx: got %0d expected 0", class_idx); end
        checks++; if (class_count !== 8'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", class_count); end
        do_accept();
    endtask

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b0;
        spike_in  = '0;
        start     = 1'b0;
        out_ready = 1'b0;
        ce_s      = 1'b0;
        spike_s   = '0;
        start_s   = 1'b0;
        ready_s   = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_saturation();
        test_backpressure();
        test_ce_gaps();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
